// File: rtl/npc_bus_pkg.sv
// Shared types for the NPC memory-port arbiter: owner/state encodings and the bus request payload.
package npc_bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_MW = BUS_DW / 8;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic              wen;
        logic [BUS_MW-1:0] wmask;
        logic [BUS_DW-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: bit 0 = IFU, bit 1 = LSU; a tie goes to whoever was not last owner.
module arb_rr2
    import npc_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_e     i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_req;
        if (&i_req) begin
            o_grant = (i_last == OWN_IFU) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the NPC memory port between IFU and LSU, one outstanding transaction at a time.
// Define ARB_TIMEOUT_EN to add a watchdog that answers the owner with an error after TIMEOUT_CYCLES.
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_AW,
    parameter int unsigned DATA_WIDTH = BUS_DW
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_addr,
    output logic                    o_ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_ifu_rdata,
    output logic                    o_ifu_rsp_err,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_addr,
    input  logic                    i_lsu_wen,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_wmask,
    input  logic [DATA_WIDTH-1:0]   i_lsu_wdata,
    output logic                    o_lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_lsu_rdata,
    output logic                    o_lsu_rsp_err,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_wen,
    output logic [DATA_WIDTH/8-1:0] o_mem_wmask,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    input  logic                    i_mem_rsp_err
);

    arb_state_e r_state;
    arb_state_e w_next;
    owner_e     r_owner;
    owner_e     r_last;
    owner_e     w_win;
    bus_req_t   r_req;
    bus_req_t   w_ifu_req;
    bus_req_t   w_lsu_req;
    bus_req_t   w_sel_req;
    logic       r_mem_req_valid;
    logic [1:0] w_grant;
    logic       w_rsp_fire;
    logic       w_tmo_fire;
    logic       w_done;

    arb_rr2 u_rr2 (
        .i_req   ({i_lsu_req_valid, i_ifu_req_valid}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // IFU requests are always reads with an empty mask
    always_comb begin
        w_ifu_req       = '0;
        w_ifu_req.addr  = BUS_AW'(i_ifu_addr);
        w_lsu_req       = '0;
        w_lsu_req.addr  = BUS_AW'(i_lsu_addr);
        w_lsu_req.wen   = i_lsu_wen;
        w_lsu_req.wmask = BUS_MW'(i_lsu_wmask);
        w_lsu_req.wdata = BUS_DW'(i_lsu_wdata);
        w_sel_req       = w_grant[1] ? w_lsu_req : w_ifu_req;
    end

    // rst gates everything so a response or grant can never leak out while reset is held
    assign w_rsp_fire = rst && (r_state == RSP) && i_mem_rsp_valid;
    assign w_done     = w_rsp_fire || w_tmo_fire;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst || (r_state == IDLE)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign w_tmo_fire = rst && (r_state != IDLE) && !w_rsp_fire
                        && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES));
`else
    assign w_tmo_fire = 1'b0;
`endif

    always_comb begin
        w_next          = r_state;
        w_win           = r_owner;
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (rst && (|w_grant)) begin
                    o_ifu_req_ready = w_grant[0];
                    o_lsu_req_ready = w_grant[1];
                    w_win           = w_grant[1] ? OWN_LSU : OWN_IFU;
                    w_next          = REQ;
                end
            end
            REQ: begin
                if (i_mem_req_ready) begin
                    w_next = RSP;
                end
            end
            RSP: begin
                if (i_mem_rsp_valid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_tmo_fire) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_owner         <= OWN_IFU;
            r_last          <= OWN_IFU;
            r_req           <= '0;
            r_mem_req_valid <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_mem_req_valid <= (w_next == REQ);
            if ((r_state == IDLE) && (w_next == REQ)) begin
                r_req   <= w_sel_req;
                r_owner <= w_win;
            end
            if (w_done) begin
                r_last <= r_owner;
            end
        end
    end

    // A watchdog completion returns zero data with the error flag set
    always_comb begin
        o_ifu_rsp_valid = 1'b0;
        o_ifu_rdata     = '0;
        o_ifu_rsp_err   = 1'b0;
        o_lsu_rsp_valid = 1'b0;
        o_lsu_rdata     = '0;
        o_lsu_rsp_err   = 1'b0;
        if (w_done) begin
            if (r_owner == OWN_IFU) begin
                o_ifu_rsp_valid = 1'b1;
                o_ifu_rdata     = w_rsp_fire ? i_mem_rdata : '0;
                o_ifu_rsp_err   = w_rsp_fire ? i_mem_rsp_err : 1'b1;
            end else begin
                o_lsu_rsp_valid = 1'b1;
                o_lsu_rdata     = w_rsp_fire ? i_mem_rdata : '0;
                o_lsu_rsp_err   = w_rsp_fire ? i_mem_rsp_err : 1'b1;
            end
        end
    end

    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_addr      = ADDR_WIDTH'(r_req.addr);
    assign o_mem_wen       = r_req.wen;
    assign o_mem_wmask     = (DATA_WIDTH/8)'(r_req.wmask);
    assign o_mem_wdata     = DATA_WIDTH'(r_req.wdata);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the timeout scenario follows ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [3:0]  lsu_wmask;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_err;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
`ifdef ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_ifu_req_valid (ifu_req_valid),
        .o_ifu_req_ready (ifu_req_ready),
        .i_ifu_addr      (ifu_addr),
        .o_ifu_rsp_valid (ifu_rsp_valid),
        .o_ifu_rdata     (ifu_rdata),
        .o_ifu_rsp_err   (ifu_rsp_err),
        .i_lsu_req_valid (lsu_req_valid),
        .o_lsu_req_ready (lsu_req_ready),
        .i_lsu_addr      (lsu_addr),
        .i_lsu_wen       (lsu_wen),
        .i_lsu_wmask     (lsu_wmask),
        .i_lsu_wdata     (lsu_wdata),
        .o_lsu_rsp_valid (lsu_rsp_valid),
        .o_lsu_rdata     (lsu_rdata),
        .o_lsu_rsp_err   (lsu_rsp_err),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_wen       (mem_wen),
        .o_mem_wmask     (mem_wmask),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rdata     (mem_rdata),
        .i_mem_rsp_err   (mem_rsp_err)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        ifu_addr = 32'h1000; lsu_addr = 32'h2000; lsu_wen = 1'b1; lsu_wmask = 4'h3; lsu_wdata = 32'h55;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234; mem_rsp_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {ifu_req_ready, lsu_req_ready}); end
            checks++; if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err} !== 4'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0000", {ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}); end
            checks++; if ({ifu_rdata, lsu_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {ifu_rdata, lsu_rdata}); end
            checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== 70'h0) begin failures++; $display("FAIL reset_mem got=%h exp=0", {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
        end
        next_cycle();
        rst = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        @(negedge clk);
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin failures++; $display("FAIL first_tie_lsu got=%b exp=10", {lsu_req_ready, ifu_req_ready}); end
        next_cycle();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h2000, 1'b1, 4'h3, 32'h55}) begin failures++; $display("FAIL first_tie_mem got=%h", {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({lsu_rsp_valid, lsu_rdata, lsu_rsp_err, ifu_rsp_valid} !== {1'b1, 32'h1234, 1'b0, 1'b0}) begin failures++; $display("FAIL first_tie_rsp got=%h", {lsu_rsp_valid, lsu_rdata, lsu_rsp_err, ifu_rsp_valid}); end
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
        @(negedge clk);
        checks++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b100) begin failures++; $display("FAIL ifu_accept got=%b exp=100", {ifu_req_ready, lsu_req_ready, mem_req_valid}); end
        next_cycle();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0}) begin failures++; $display("FAIL ifu_mem got=%h", {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
        checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL ifu_rsp_early got=%b exp=0", ifu_rsp_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err} !== {1'b1, 32'h0010_0073, 1'b0}) begin failures++; $display("FAIL ifu_rsp got=%h exp=%h", {ifu_rsp_valid, ifu_rdata, ifu_rsp_err}, {1'b1, 32'h0010_0073, 1'b0}); end
        checks++; if ({lsu_rsp_valid, lsu_rdata} !== 33'h0) begin failures++; $display("FAIL ifu_rsp_lsu_quiet got=%h exp=0", {lsu_rsp_valid, lsu_rdata}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({mem_req_valid, ifu_rsp_valid} !== 2'b00) begin failures++; $display("FAIL ifu_back_idle got=%b exp=00", {mem_req_valid, ifu_rsp_valid}); end
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_tie();
        logic exp_lsu;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0100; lsu_wen = 1'b1; lsu_wmask = 4'hF; lsu_wdata = 32'hDEAD_BEEF;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_lsu = ((k % 2) == 0);
            mem_rdata = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            checks++; if ({lsu_req_ready, ifu_req_ready} !== (exp_lsu ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_grant[%0d] got=%b exp=%b", k, {lsu_req_ready, ifu_req_ready}, exp_lsu ? 2'b10 : 2'b01); end
            next_cycle();
            @(negedge clk);
            if (exp_lsu) begin
                checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h8000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF}) begin failures++; $display("FAIL tie_mem_lsu[%0d] got=%h", k, {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
            end else begin
                checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h8000_0004, 1'b0, 4'h0, 32'h0}) begin failures++; $display("FAIL tie_mem_ifu[%0d] got=%h", k, {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
            end
            checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b00) begin failures++; $display("FAIL tie_ready_req[%0d] got=%b exp=00", k, {lsu_req_ready, ifu_req_ready}); end
            next_cycle();
            @(negedge clk);
            if (exp_lsu) begin
                checks++; if ({lsu_rsp_valid, lsu_rdata, ifu_rsp_valid, ifu_rdata} !== {1'b1, 32'hA000_0000 + 32'(k), 1'b0, 32'h0}) begin failures++; $display("FAIL tie_rsp_lsu[%0d] got=%h", k, {lsu_rsp_valid, lsu_rdata, ifu_rsp_valid, ifu_rdata}); end
            end else begin
                checks++; if ({ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, lsu_rdata} !== {1'b1, 32'hA000_0000 + 32'(k), 1'b0, 32'h0}) begin failures++; $display("FAIL tie_rsp_ifu[%0d] got=%h", k, {ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, lsu_rdata}); end
            end
            checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b00) begin failures++; $display("FAIL tie_ready_rsp[%0d] got=%b exp=00", k, {lsu_req_ready, ifu_req_ready}); end
            next_cycle();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b1; lsu_wmask = 4'b0101; lsu_wdata = 32'h1234_5678;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_rsp_err = 1'b1;
        @(negedge clk);
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", {lsu_req_ready, ifu_req_ready}); end
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata} !== {1'b1, 32'h8000_0200, 1'b1, 4'b0101, 32'h1234_5678}) begin failures++; $display("FAIL bp_stable[%0d] got=%h", c, {mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata}); end
            checks++; if ({lsu_req_ready, ifu_req_ready, lsu_rsp_valid, ifu_rsp_valid} !== 4'b0) begin failures++; $display("FAIL bp_quiet[%0d] got=%b exp=0000", c, {lsu_req_ready, ifu_req_ready, lsu_rsp_valid, ifu_rsp_valid}); end
            next_cycle();
        end
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        next_cycle();
        mem_req_ready = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req_valid, lsu_rsp_valid, ifu_rsp_valid, lsu_req_ready, ifu_req_ready} !== 5'b0) begin failures++; $display("FAIL bp_rsp_wait got=%b exp=00000", {mem_req_valid, lsu_rsp_valid, ifu_rsp_valid, lsu_req_ready, ifu_req_ready}); end
        next_cycle();
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        checks++; if ({lsu_rsp_valid, lsu_rdata, lsu_rsp_err} !== {1'b1, 32'hCAFE_F00D, 1'b1}) begin failures++; $display("FAIL bp_rsp_owner got=%h", {lsu_rsp_valid, lsu_rdata, lsu_rsp_err}); end
        checks++; if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err} !== 34'h0) begin failures++; $display("FAIL bp_rsp_other got=%h exp=0", {ifu_rsp_valid, ifu_rdata, ifu_rsp_err}); end
        next_cycle();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_req_ready = 1'b1;
        lsu_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_rsp();
        @(negedge clk);
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b01) begin failures++; $display("FAIL rr_after_bp got=%b exp=01", {lsu_req_ready, ifu_req_ready}); end
        next_cycle();
        ifu_req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_pre got=%b exp=0", ifu_rsp_valid); end
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin failures++; $display("FAIL mid_rsp_in_reset got=%b exp=00", {ifu_rsp_valid, lsu_rsp_valid}); end
        next_cycle();
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0020;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0300; lsu_wen = 1'b0; lsu_wmask = 4'h0; lsu_wdata = 32'h0;
        @(negedge clk);
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_addr} !== 35'h0) begin failures++; $display("FAIL stray_rsp got=%h exp=0", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_addr}); end
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin failures++; $display("FAIL idle_after_reset got=%b exp=10", {lsu_req_ready, ifu_req_ready}); end
        next_cycle();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_0300}) begin failures++; $display("FAIL post_reset_mem got=%h", {mem_req_valid, mem_addr}); end
        next_cycle();
        @(negedge clk);
        checks++; if ({lsu_rsp_valid, lsu_rdata, ifu_rsp_valid} !== {1'b1, 32'h7777_7777, 1'b0}) begin failures++; $display("FAIL post_reset_rsp got=%h", {lsu_rsp_valid, lsu_rdata, ifu_rsp_valid}); end
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_timeout();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = 32'hBAD0_BAD0; mem_rsp_err = 1'b0;
        @(negedge clk);
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL tmo_accept got=%b exp=1", ifu_req_ready); end
        next_cycle();
        ifu_req_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (ifu_rsp_valid !== 1'b0) begin failures++; $display("FAIL tmo_early[%0d] got=%b exp=0", c, ifu_rsp_valid); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin failures++; $display("FAIL tmo_fire got=%h", {ifu_rsp_valid, ifu_rdata, ifu_rsp_err, lsu_rsp_valid}); end
        next_cycle();
        mem_rsp_valid = 1'b1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0400; lsu_wen = 1'b0;
        @(negedge clk);
        checks++; if ({ifu_rsp_valid, lsu_rsp_valid, lsu_req_ready} !== 3'b001) begin failures++; $display("FAIL tmo_late_rsp got=%b exp=001", {ifu_rsp_valid, lsu_rsp_valid, lsu_req_ready}); end
        next_cycle();
        lsu_req_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if ({lsu_rsp_valid, lsu_rdata, lsu_rsp_err} !== {1'b1, 32'hBAD0_BAD0, 1'b0}) begin failures++; $display("FAIL tmo_next_txn got=%h", {lsu_rsp_valid, lsu_rdata, lsu_rsp_err}); end
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++; if ({ifu_rsp_valid, ifu_req_ready} !== 2'b00) begin failures++; $display("FAIL wait_forever[%0d] got=%b exp=00", c, {ifu_rsp_valid, ifu_req_ready}); end
            next_cycle();
        end
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        checks++; if ({ifu_rsp_valid, ifu_rdata, ifu_rsp_err} !== {1'b1, 32'hBAD0_BAD0, 1'b0}) begin failures++; $display("FAIL late_rsp got=%h", {ifu_rsp_valid, ifu_rdata, ifu_rsp_err}); end
`endif
        next_cycle();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_tie();
        test_backpressure();
        test_reset_mid_rsp();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
